muldiv_ctrl: RTL and testbench

//  Sequencer for the HI/LO unit of the multicycle CPU. Takes one MULT/DIV request from the main

---
 rtl/muldiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the HI/LO unit: issues one MULT/DIV to the external units, waits out their
// fixed latency, then captures the result into HI/LO. It also handles MTHI/MTLO writes.
module muldiv_ctrl #(
    parameter int DIV_LAT  = 32,
    parameter int MULT_LAT = 33,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wdata,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        DControl,
    output logic        MControl,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        div0_exc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             opR_q, opR_d;
    logic [31:0]      opA_q, opA_d;
    logic [31:0]      opB_q, opB_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             dCtl_q, dCtl_d;
    logic             mCtl_q, mCtl_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    // The divider's Div0 flag is sticky, so it is only trusted in the first WAIT cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opR_d   = opR_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dCtl_d  = 1'b0;
        mCtl_d  = 1'b0;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wdata;
                if (lo_wr) lo_d = wdata;
                if (start) begin
                    opA_d   = a_in;
                    opB_d   = b_in;
                    opR_d   = op;
                    dCtl_d  = op;
                    mCtl_d  = ~op;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = opR_q ? DIV_INIT : MULT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (opR_q && (cnt_q == DIV_INIT) && div_zero) begin
                    div0_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = opR_q ? div_hi : mult_hi;
                    lo_d    = opR_q ? div_lo : mult_lo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opR_q   <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dCtl_q  <= 1'b0;
            mCtl_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opR_q   <= opR_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dCtl_q  <= dCtl_d;
            mCtl_q  <= mCtl_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign op_a     = opA_q;
    assign op_b     = opB_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign DControl = dCtl_q;
    assign MControl = mCtl_q;
    assign done     = done_q;
    assign div0_exc = div0_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural fixed-latency div/mult units plus an expected-result queue
// filled at issue time and drained when done/div0_exc appears.
module tb_muldiv_ctrl;

    localparam int DIV_LAT  = 32;
    localparam int MULT_LAT = 33;

    logic        clk = 1'b0;
    logic        reset, start, op, hi_wr, lo_wr;
    logic [31:0] a_in, b_in, wdata;
    logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
    logic        div_zero = 1'b0;
    logic [31:0] op_a, op_b, hi, lo;
    logic        DControl, MControl, busy, done, div0_exc;

    muldiv_ctrl #(.DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .div_hi(div_hi), .div_lo(div_lo),
        .div_zero(div_zero), .mult_hi(mult_hi), .mult_lo(mult_lo), .op_a(op_a), .op_b(op_b),
        .DControl(DControl), .MControl(MControl), .busy(busy), .hi(hi), .lo(lo),
        .done(done), .div0_exc(div0_exc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] divQ(input logic [31:0] a, input logic [31:0] b);
        int x, y;
        x = a; y = b;
        return 32'(x / y);
    endfunction

    function automatic logic [31:0] divR(input logic [31:0] a, input logic [31:0] b);
        int x, y;
        x = a; y = b;
        return 32'(x % y);
    endfunction

    function automatic logic [63:0] mulP(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a)); y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Unit models: result registered on the LAT-th edge counting the xControl edge as the first.
    int dCnt = 0, mCnt = 0;
    always @(posedge clk) begin
        if (DControl) begin
            dCnt     <= DIV_LAT - 1;
            div_zero <= (op_b == 32'd0);
            div_hi   <= 32'hDEADBEEF;
            div_lo   <= 32'hDEADBEEF;
        end else if (dCnt > 0) begin
            dCnt <= dCnt - 1;
            if (dCnt == 1 && !div_zero) begin
                div_lo <= divQ(op_a, op_b);
                div_hi <= divR(op_a, op_b);
            end
        end
        if (MControl) begin
            mCnt    <= MULT_LAT - 1;
            mult_hi <= 32'hBADC0FFE;
            mult_lo <= 32'hBADC0FFE;
        end else if (mCnt > 0) begin
            mCnt <= mCnt - 1;
            if (mCnt == 1) {mult_hi, mult_lo} <= mulP(op_a, op_b);
        end
    end

    typedef struct {
        bit          isDiv0;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        scoreboard[$];
    exp_t        e;
    logic [31:0] archHi, archLo;
    int          startCyc;
    int          nTests = 0, nFail = 0;
    int          lat, busyCnt, dPulses, mPulses, dAt, mAt, extra;
    bit          gotDone, gotDiv0;

    task automatic issueOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eHi, input logic [31:0] eLo, input bit eDiv0);
        exp_t x;
        start    = 1'b1;
        op       = o;
        a_in     = a;
        b_in     = b;
        startCyc = cyc;
        x.isDiv0 = eDiv0;
        x.hi     = eHi;
        x.lo     = eLo;
        x.lat    = eDiv0 ? 3 : (o ? DIV_LAT + 2 : MULT_LAT + 2);
        scoreboard.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done or div0_exc; leaves the caller at the negedge of that cycle.
    task automatic waitResult();
        lat = -1; gotDone = 0; gotDiv0 = 0; busyCnt = 0;
        dPulses = 0; mPulses = 0; dAt = -1; mAt = -1;
        for (int k = 0; k < 80; k++) begin
            if (busy) busyCnt++;
            if (DControl) begin dPulses++; dAt = cyc - startCyc; end
            if (MControl) begin mPulses++; mAt = cyc - startCyc; end
            if (done || div0_exc) begin
                gotDone = done; gotDiv0 = div0_exc; lat = cyc - startCyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic countStrayDone(input int n);
        extra = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done || div0_exc) extra++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        a_in = '0; b_in = '0; wdata = '0;
        repeat (2) @(negedge clk);
        nTests++;
        if ({hi, lo, op_a, op_b, busy, done, div0_exc, DControl, MControl} !== '0) begin
            nFail++; $display("[TB] FAIL reset_state: hi=%h lo=%h opa=%h opb=%h busy=%b done=%b d0=%b dc=%b mc=%b, want all 0",
                              hi, lo, op_a, op_b, busy, done, div0_exc, DControl, MControl);
        end
        reset = 1'b0;
        archHi = '0; archLo = '0;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        hi_wr = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h5A5A_1234;
        nTests++;
        if (hi !== 32'hA5A5_0001) begin nFail++; $display("[TB] FAIL mthi: got %h want %h", hi, 32'hA5A5_0001); end
        @(negedge clk);
        lo_wr = 1'b0;
        nTests++;
        if (lo !== 32'h5A5A_1234) begin nFail++; $display("[TB] FAIL mtlo: got %h want %h", lo, 32'h5A5A_1234); end
        archHi = 32'hA5A5_0001; archLo = 32'h5A5A_1234;
    endtask

    task automatic test_div_basic();
        issueOp(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        nTests++;
        if ({op_a, op_b} !== {32'd7, 32'hFFFF_FFFE}) begin nFail++; $display("[TB] FAIL div_operands: got %h/%h want 7/fffffffe", op_a, op_b); end
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat) begin nFail++; $display("[TB] FAIL div_latency: done=%b at %0d want done at %0d", gotDone, lat, e.lat); end
        nTests++;
        if (dPulses != 1 || dAt != 1 || mPulses != 0) begin nFail++; $display("[TB] FAIL div_dcontrol: dpulses=%0d at %0d mpulses=%0d want 1 at 1, 0", dPulses, dAt, mPulses); end
        nTests++;
        if (busyCnt != 33) begin nFail++; $display("[TB] FAIL div_busy: got %0d cycles want 33", busyCnt); end
        nTests++;
        if ({hi, lo} !== {e.hi, e.lo}) begin nFail++; $display("[TB] FAIL div_result: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        archHi = e.hi; archLo = e.lo;
        @(negedge clk);
        nTests++;
        if (done !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL div_done_width: done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_div_neg();
        issueOp(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            nFail++; $display("[TB] FAIL div_neg: done=%b lat=%0d hi/lo=%h/%h want lat %0d %h/%h", gotDone, lat, hi, lo, e.lat, e.hi, e.lo);
        end
        archHi = e.hi; archLo = e.lo;
        @(negedge clk);
        nTests++;
        if (done !== 1'b0) begin nFail++; $display("[TB] FAIL div_neg_done_width: done=%b want 0", done); end
    endtask

    task automatic test_div_zero();
        issueOp(1'b1, 32'd5, 32'd0, archHi, archLo, 1'b1);
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDiv0 !== 1'b1 || gotDone !== 1'b0 || lat != e.lat) begin
            nFail++; $display("[TB] FAIL div0_pulse: div0=%b done=%b at %0d want div0 at %0d", gotDiv0, gotDone, lat, e.lat);
        end
        nTests++;
        if ({hi, lo} !== {e.hi, e.lo}) begin nFail++; $display("[TB] FAIL div0_hilo: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        @(negedge clk);
        nTests++;
        if (div0_exc !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL div0_after: div0=%b busy=%b want 0/0", div0_exc, busy); end
        countStrayDone(40);
        nTests++;
        if (extra != 0) begin nFail++; $display("[TB] FAIL div0_no_done: got %0d pulses want 0", extra); end
    endtask

    task automatic test_mult();
        issueOp(1'b0, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (mPulses != 1 || mAt != 1 || dPulses != 0) begin nFail++; $display("[TB] FAIL mult_mcontrol: mpulses=%0d at %0d dpulses=%0d want 1 at 1, 0", mPulses, mAt, dPulses); end
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat) begin nFail++; $display("[TB] FAIL mult_latency: done=%b at %0d want %0d", gotDone, lat, e.lat); end
        nTests++;
        if ({hi, lo} !== {e.hi, e.lo}) begin nFail++; $display("[TB] FAIL mult_result: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        archHi = e.hi; archLo = e.lo;
        @(negedge clk);
    endtask

    task automatic test_ignore_while_busy();
        issueOp(1'b1, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd99; b_in = 32'd98; hi_wr = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
        nTests++;
        if (hi !== archHi || op_a !== 32'd20 || MControl !== 1'b0) begin
            nFail++; $display("[TB] FAIL busy_ignore: hi=%h opa=%h mc=%b want %h/%h/0", hi, op_a, MControl, archHi, 32'd20);
        end
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            nFail++; $display("[TB] FAIL busy_result: done=%b lat=%0d %h/%h want lat %0d %h/%h", gotDone, lat, hi, lo, e.lat, e.hi, e.lo);
        end
        archHi = e.hi; archLo = e.lo;
        countStrayDone(40);
        nTests++;
        if (extra != 0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL busy_single_done: extra=%0d busy=%b want 0/0", extra, busy); end
    endtask

    task automatic test_reset_mid();
        issueOp(1'b1, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nTests++;
        if ({hi, lo, op_a, op_b, busy, done, div0_exc, DControl, MControl} !== '0) begin
            nFail++; $display("[TB] FAIL reset_mid: hi=%h lo=%h opa=%h opb=%h busy=%b done=%b, want all 0", hi, lo, op_a, op_b, busy, done);
        end
        reset = 1'b0;
        void'(scoreboard.pop_front());
        archHi = '0; archLo = '0;
        @(negedge clk);
        issueOp(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            nFail++; $display("[TB] FAIL reset_reissue: done=%b lat=%0d %h/%h want lat %0d %h/%h", gotDone, lat, hi, lo, e.lat, e.hi, e.lo);
        end
        archHi = e.hi; archLo = e.lo;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issueOp(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || {hi, lo} !== {e.hi, e.lo}) begin nFail++; $display("[TB] FAIL b2b_mult: done=%b %h/%h want %h/%h", gotDone, hi, lo, e.hi, e.lo); end
        lo_wr = 1'b1; wdata = 32'hCAFE_F00D;
        issueOp(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        lo_wr = 1'b0;
        nTests++;
        if (lo !== 32'hCAFE_F00D || busy !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_mtlo_start: lo=%h busy=%b want cafef00d/1", lo, busy); end
        waitResult();
        e = scoreboard.pop_front();
        nTests++;
        if (gotDone !== 1'b1 || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            nFail++; $display("[TB] FAIL b2b_div: done=%b lat=%0d %h/%h want lat %0d %h/%h", gotDone, lat, hi, lo, e.lat, e.hi, e.lo);
        end
        archHi = e.hi; archLo = e.lo;
    endtask

    task automatic test_random();
        logic        o;
        logic [31:0] a, b;
        logic [63:0] p;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom_range(1, 32'h7FFF_FFFF);
            p = mulP(a, b);
            if (o) issueOp(o, a, b, divR(a, b), divQ(a, b), 1'b0);
            else   issueOp(o, a, b, p[63:32], p[31:0], 1'b0);
            waitResult();
            e = scoreboard.pop_front();
            nTests++;
            if (gotDone !== 1'b1 || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
                nFail++; $display("[TB] FAIL random_%0d: op=%b done=%b lat=%0d %h/%h want lat %0d %h/%h", i, o, gotDone, lat, hi, lo, e.lat, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_div_basic();
        test_div_neg();
        test_div_zero();
        test_mult();
        test_ignore_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
